// File: rtl/dct_stream_checker_if.sv
// dct_stream_checker_if: stream bundle between a vector source / golden memory and the checker.
//   dut_valid  source -> checker   dut_data holds one vector this cycle
//   dut_data   source -> checker   LANES*DW, lane i at [i*DW +: DW]
//   exp_addr   checker -> memory   golden-memory read address
//   exp_data   memory -> checker   golden vector, valid one cycle after exp_addr
// Modports: master = source/memory side, slave = checker side.
interface dct_stream_checker_if #(
  parameter int LANES = 16,
  parameter int DW    = 11,
  parameter int AW    = 9
);
  logic                  dut_valid;
  logic [LANES*DW-1:0]   dut_data;
  logic [AW-1:0]         exp_addr;
  logic [LANES*DW-1:0]   exp_data;

  modport master (
    output dut_valid,
    output dut_data,
    output exp_data,
    input  exp_addr
  );

  modport slave (
    input  dut_valid,
    input  dut_data,
    input  exp_data,
    output exp_addr
  );
endinterface

// File: rtl/dct_stream_checker.sv
// dct_stream_checker: compares a stream of LANES-wide coefficient vectors against a golden
// memory and keeps per-group error counts plus the location of the first mismatch.
// Optional feature macro: CHK_TOLERANCE_EN (lane mismatches only when |dut-exp| > TOL).
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           one-cycle pulse beginning a run (ignored while busy)
//   stream          slave side of dct_stream_checker_if (dut_valid/dut_data/exp_addr/exp_data)
//   busy            high in RUN and DRAIN
//   done, pass      run complete; pass = done and every error counter zero
//   vec_cnt         vectors accepted this run (stops at NUM_VEC)
//   err_cnt         saturating per-group mismatch counters, group g at [g*CW +: CW]
//   first_err_*     first mismatching vector index and its lowest mismatching lane
module dct_stream_checker #(
  parameter int LANES   = 16,
  parameter int DW      = 11,
  parameter int NUM_VEC = 512,
  parameter int GRP     = 8,
  parameter int CW      = 16,
  parameter int TOL     = 1,
  localparam int NG     = LANES / GRP,
  localparam int AW     = $clog2(NUM_VEC),
  localparam int LW     = $clog2(LANES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  dct_stream_checker_if.slave   stream,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [AW:0]           vec_cnt,
  output logic [NG*CW-1:0]      err_cnt,
  output logic                  first_err_vld,
  output logic [AW-1:0]         first_err_idx,
  output logic [LW-1:0]         first_err_lane
);

  if ((LANES % GRP) != 0 || TOL < 0) begin : g_bad_cfg
    $error("dct_stream_checker: LANES must be a multiple of GRP and TOL non-negative");
  end

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]          r_state;
  logic                r_drain;
  logic [AW:0]         r_vec_cnt;
  logic                r_s1_vld;
  logic [LANES*DW-1:0] r_s1_data;
  logic [AW-1:0]       r_s1_idx;
  logic [NG*CW-1:0]    r_err_cnt;
  logic                r_first_vld;
  logic [AW-1:0]       r_first_idx;
  logic [LW-1:0]       r_first_lane;

  logic                w_accept;
  logic                w_last;
  logic                w_start;
  logic [LANES-1:0]    w_lane_mis;
  logic [NG-1:0]       w_grp_mis;
  logic                w_s1_mis;
  logic [LW-1:0]       w_low_lane;

  assign w_accept = (r_state == StRun) && stream.dut_valid;
  assign w_last   = w_accept && (r_vec_cnt == (AW+1)'(NUM_VEC - 1));
  assign w_start  = start && ((r_state == StIdle) || (r_state == StDone));

  // Stage-1 vector meets exp_data here: the golden read issued at accept time lands now.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DW-1:0] w_a;
    logic [DW-1:0] w_b;
    assign w_a = r_s1_data[i*DW +: DW];
    assign w_b = stream.exp_data[i*DW +: DW];
`ifdef CHK_TOLERANCE_EN
    // Sign-extend to DW+1 bits so the difference cannot overflow.
    logic signed [DW:0] w_diff;
    logic [DW:0]        w_abs;
    assign w_diff        = $signed({w_a[DW-1], w_a}) - $signed({w_b[DW-1], w_b});
    assign w_abs         = w_diff[DW] ? $unsigned(-w_diff) : $unsigned(w_diff);
    assign w_lane_mis[i] = w_abs > (DW+1)'(TOL);
`else
    assign w_lane_mis[i] = (w_a != w_b);
`endif
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    assign w_grp_mis[g] = r_s1_vld && (|w_lane_mis[g*GRP +: GRP]);
  end

  assign w_s1_mis = r_s1_vld && (|w_lane_mis);

  // Descending scan so the lowest mismatching lane wins.
  always_comb begin
    w_low_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (w_lane_mis[i]) w_low_lane = LW'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_drain      <= 1'b0;
      r_vec_cnt    <= '0;
      r_s1_vld     <= 1'b0;
      r_s1_data    <= '0;
      r_s1_idx     <= '0;
      r_err_cnt    <= '0;
      r_first_vld  <= 1'b0;
      r_first_idx  <= '0;
      r_first_lane <= '0;
    end else begin
      unique case (r_state)
        StIdle:  if (start) r_state <= StRun;
        StRun: begin
          if (w_last) begin
            r_state <= StDrain;
            r_drain <= 1'b0;
          end
        end
        StDrain: begin
          if (r_drain) r_state <= StDone;
          else         r_drain <= 1'b1;
        end
        StDone:  if (start) r_state <= StRun;
        default: r_state <= StIdle;
      endcase

      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_data <= stream.dut_data;
        r_s1_idx  <= r_vec_cnt[AW-1:0];
      end

      if (w_start) begin
        r_vec_cnt    <= '0;
        r_err_cnt    <= '0;
        r_first_vld  <= 1'b0;
        r_first_idx  <= '0;
        r_first_lane <= '0;
      end else begin
        if (w_accept) r_vec_cnt <= r_vec_cnt + 1'b1;
        for (int g = 0; g < NG; g++) begin
          if (w_grp_mis[g] && (r_err_cnt[g*CW +: CW] != {CW{1'b1}})) begin
            r_err_cnt[g*CW +: CW] <= r_err_cnt[g*CW +: CW] + 1'b1;
          end
        end
        if (w_s1_mis && !r_first_vld) begin
          r_first_vld  <= 1'b1;
          r_first_idx  <= r_s1_idx;
          r_first_lane <= w_low_lane;
        end
      end
    end
  end

  assign stream.exp_addr = r_vec_cnt[AW-1:0];
  assign busy            = (r_state == StRun) || (r_state == StDrain);
  assign done            = (r_state == StDone);
  assign pass            = done && (r_err_cnt == '0);
  assign vec_cnt         = r_vec_cnt;
  assign err_cnt         = r_err_cnt;
  assign first_err_vld   = r_first_vld;
  assign first_err_idx   = r_first_idx;
  assign first_err_lane  = r_first_lane;

endmodule

// File: tb/tb_dct_stream_checker.sv
module tb_dct_stream_checker;
  localparam int LANES   = 16;
  localparam int DW      = 11;
  localparam int NUM_VEC = 512;
  localparam int AW      = 9;
  localparam int VW      = LANES * DW;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dct_stream_checker_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus_a ();
  dct_stream_checker_if #(.LANES(LANES), .DW(DW), .AW(AW)) bus_b ();

  logic          a_busy, a_done, a_pass, a_fvld;
  logic [AW:0]   a_vec;
  logic [31:0]   a_err;
  logic [AW-1:0] a_fidx;
  logic [3:0]    a_flane;
  logic          b_busy, b_done, b_pass, b_fvld;
  logic [AW:0]   b_vec;
  logic [7:0]    b_err;
  logic [AW-1:0] b_fidx;
  logic [3:0]    b_flane;

  dct_stream_checker dut_a (
    .clk(clk), .rst(rst), .start(start), .stream(bus_a.slave),
    .busy(a_busy), .done(a_done), .pass(a_pass), .vec_cnt(a_vec), .err_cnt(a_err),
    .first_err_vld(a_fvld), .first_err_idx(a_fidx), .first_err_lane(a_flane)
  );

  dct_stream_checker #(.CW(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stream(bus_b.slave),
    .busy(b_busy), .done(b_done), .pass(b_pass), .vec_cnt(b_vec), .err_cnt(b_err),
    .first_err_vld(b_fvld), .first_err_idx(b_fidx), .first_err_lane(b_flane)
  );

  // Golden memory: synchronous read, data one cycle after the address.
  logic [VW-1:0] gold [NUM_VEC];
  always @(posedge clk) bus_a.exp_data <= gold[bus_a.exp_addr];
  always @(posedge clk) bus_b.exp_data <= gold[bus_b.exp_addr];
  assign bus_b.dut_valid = bus_a.dut_valid;
  assign bus_b.dut_data  = bus_a.dut_data;

  typedef struct {
    int          id;
    logic [15:0] e0, e1;
    logic [3:0]  b0, b1;
    bit          chk_b;
    logic [AW:0] vc;
    logic        pass, fvld;
    logic [AW-1:0] fidx;
    logic [3:0]  flane;
    int          done_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  logic prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: each rising done is one finished run; compare against the oldest expectation.
  always @(negedge clk) begin
    if (a_done && !prev_done) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done=1 expected no run pending");
      end else begin
        m = sb.pop_front();
        $display("run %0d finished at cycle %0d", m.id, cyc);
        check("done_cycle", cyc,        m.done_cyc);
        check("vec_cnt",    a_vec,      m.vc);
        check("err_cnt0",   a_err[15:0],  m.e0);
        check("err_cnt1",   a_err[31:16], m.e1);
        check("pass",       a_pass,     m.pass);
        check("first_vld",  a_fvld,     m.fvld);
        check("first_idx",  a_fidx,     m.fidx);
        check("first_lane", a_flane,    m.flane);
        check("busy_done",  a_busy,     1'b0);
        if (m.chk_b) begin
          check("sat_err0", b_err[3:0], m.b0);
          check("sat_err1", b_err[7:4], m.b1);
          check("sat_pass", b_pass,     1'b0);
        end
      end
    end
    prev_done = a_done;
  end

  function automatic logic [DW-1:0] gold_lane(input int k, input int i);
    return DW'(((k * 5 + i * 3) % 1000) - 500);
  endfunction

  function automatic logic [VW-1:0] make_vec(input int k, input int mode);
    logic [VW-1:0] v;
    v = gold[k];
    case (mode)
      1: begin
        if (k == 37) v[3*DW +: DW] = v[3*DW +: DW] ^ 11'h040;
        if (k == 100) begin
          v[9*DW +: DW]  = v[9*DW +: DW] ^ 11'h040;
          v[15*DW +: DW] = v[15*DW +: DW] ^ 11'h040;
        end
      end
      2: v[0 +: DW] = v[0 +: DW] + 11'd1;
      3: begin
        v[0 +: DW]    = v[0 +: DW] ^ 11'h040;
        v[8*DW +: DW] = v[8*DW +: DW] ^ 11'h040;
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_busy"},  a_busy,  1'b0);
    check({tag, "_done"},  a_done,  1'b0);
    check({tag, "_pass"},  a_pass,  1'b0);
    check({tag, "_vec"},   a_vec,   0);
    check({tag, "_err"},   a_err,   0);
    check({tag, "_fvld"},  a_fvld,  1'b0);
    check({tag, "_fidx"},  a_fidx,  0);
    check({tag, "_flane"}, a_flane, 0);
    check({tag, "_addr"},  bus_a.exp_addr, 0);
  endtask

  task automatic run(input int id, input int mode, input bit gapped, input bit mid_start);
    exp_t e;
    int   last_cyc;
    last_cyc = 0;
    e = '{id: id, e0: 0, e1: 0, b0: 0, b1: 0, chk_b: 0, vc: 10'(NUM_VEC), pass: 1'b1,
          fvld: 1'b0, fidx: 0, flane: 0, done_cyc: 0};
    case (mode)
      1: begin e.e0 = 1; e.e1 = 1; e.pass = 0; e.fvld = 1; e.fidx = 37; e.flane = 3; end
      2: begin
`ifndef CHK_TOLERANCE_EN
        e.e0 = 512; e.pass = 0; e.fvld = 1;
`endif
      end
      3: begin
        e.e0 = 512; e.e1 = 512; e.b0 = 15; e.b1 = 15; e.chk_b = 1; e.pass = 0; e.fvld = 1;
      end
      default: ;
    endcase
    pulse_start();
    for (int k = 0; k < NUM_VEC; k++) begin
      bus_a.dut_valid = 1'b1;
      bus_a.dut_data  = make_vec(k, mode);
      if (mid_start && k == 100) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      bus_a.dut_valid = 1'b0;
      if (k == NUM_VEC - 1) last_cyc = cyc;
      if (gapped) begin
        @(posedge clk); #1;
      end
    end
    e.done_cyc = last_cyc + 2;
    sb.push_back(e);
    for (int i = 0; i < 12 && sb.size() != 0; i++) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done within 12 cycles expected done for run %0d", id);
      void'(sb.pop_front());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NUM_VEC; k++)
      for (int i = 0; i < LANES; i++) gold[k][i*DW +: DW] = gold_lane(k, i);
    rst = 1'b1;
    start = 1'b0;
    bus_a.dut_valid = 1'b0;
    bus_a.dut_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_zero("reset");

    run(1, 0, 1'b0, 1'b0);

    // dut_valid while in DONE must be ignored.
    bus_a.dut_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus_a.dut_valid = 1'b0;
    check("done_valid_vec", a_vec, 512);
    check("done_held",      a_done, 1'b1);
    check("done_pass",      a_pass, 1'b1);

    run(2, 1, 1'b0, 1'b0);
    run(3, 0, 1'b1, 1'b1);
    run(4, 2, 1'b0, 1'b0);
    run(5, 3, 1'b0, 1'b0);

    // Abort at vector 200 with rst colliding with start and dut_valid.
    pulse_start();
    for (int k = 0; k < 200; k++) begin
      bus_a.dut_valid = 1'b1;
      bus_a.dut_data  = make_vec(k, 3);
      @(posedge clk); #1;
    end
    check("pre_abort_busy", a_busy, 1'b1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    bus_a.dut_valid = 1'b0;
    chk_zero("abort");
    check("abort_sat", b_err, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_zero("post_abort");

    run(6, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
